// File: rtl/fir_pkg.sv
// fir_pkg: tap geometry shared with fir_accurate, tap type and feeder state.
package fir_pkg;

   localparam int NTAPS  = 6;
   localparam int DATA_W = 32;

   typedef logic signed [DATA_W-1:0] fir_tap_t;

   typedef enum logic [1:0] {
      FEED_FILL,
      FEED_SETTLE,
      FEED_PRESENT,
      FEED_HOLD
   } fir_feed_state_e;

   // Bits needed to hold 0..maxval, never less than one.
   function automatic int fir_bits(input int maxval);
      return (maxval < 2) ? 1 : $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/fir_tap_feeder_if.sv
// fir_tap_feeder_if: sample stream in, settled tap window out.
interface fir_tap_feeder_if #(
   parameter int IN_W = 12
);
   import fir_pkg::*;

   logic                    s_valid;
   logic                    s_ready;
   logic [IN_W-1:0]         s_data;
   logic [NTAPS*DATA_W-1:0] taps;
   logic                    win_valid;
   logic                    win_ready;
   logic [31:0]             win_idx;

   modport master (
      output s_valid, s_data, win_ready,
      input  s_ready, taps, win_valid, win_idx
   );

   modport slave (
      input  s_valid, s_data, win_ready,
      output s_ready, taps, win_valid, win_idx
   );

endinterface

// File: rtl/fir_delay_line.sv
// fir_delay_line: N-deep shift register, tap 1 (newest) in the flat LSBs.
module fir_delay_line
   import fir_pkg::*;
#(
   parameter int N = NTAPS,
   parameter int W = DATA_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clear_i,
   input  logic           shift_en_i,
   input  logic [W-1:0]   din_i,
   output logic [N*W-1:0] taps_o
);

   logic [W-1:0] tap_q [N];
   logic [W-1:0] tap_d [N];

   always_comb begin
      tap_d = tap_q;
      if (clear_i) begin
         tap_d = '{default: '0};
      end else if (shift_en_i) begin
         tap_d[0] = din_i;
         for (int k = 1; k < N; k++) begin
            tap_d[k] = tap_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tap_q <= '{default: '0};
      end else begin
         tap_q <= tap_d;
      end
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         taps_o[k*W +: W] = tap_q[k];
      end
   end

endmodule

// File: rtl/fir_tap_feeder.sv
// fir_tap_feeder: fills the delay line and presents a settled window to fir_accurate.
// Define FIR_TAP_PREFILL_EN to treat the zeroed taps as valid history.
module fir_tap_feeder
   import fir_pkg::*;
#(
   parameter int IN_W      = 12,
   parameter bit SIGNED_IN = 1'b0,
   parameter int SETTLE    = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   fir_tap_feeder_if.slave bus
);

   localparam int FILL_W = fir_bits(NTAPS);
   localparam int TMR_W  = fir_bits((SETTLE > 0) ? SETTLE - 1 : 0);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NTAPS);
`ifdef FIR_TAP_PREFILL_EN
   localparam logic [FILL_W-1:0] FILL_RST  = FILL_FULL;
`else
   localparam logic [FILL_W-1:0] FILL_RST  = '0;
`endif
   localparam logic [TMR_W-1:0] TMR_LOAD =
      (SETTLE > 0) ? TMR_W'(SETTLE - 1) : '0;
   localparam fir_feed_state_e ST_ARM =
      (SETTLE == 0) ? FEED_PRESENT : FEED_SETTLE;

   fir_feed_state_e   state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [31:0]       idx_q, idx_d;

   logic            s_ready;
   logic            win_valid;
   logic            accept;
   logic            consume;
   logic [IN_W-1:0] s_data;
   fir_tap_t        ext;

   assign s_data = bus.s_data;
   assign ext    = SIGNED_IN ? fir_tap_t'($signed(s_data))
                             : fir_tap_t'(s_data);

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      tmr_d     = tmr_q;
      s_ready   = 1'b0;
      win_valid = 1'b0;

      unique case (state_q)
         FEED_FILL:    s_ready = 1'b1;
         FEED_SETTLE:  s_ready = 1'b0;
         FEED_PRESENT: begin
            win_valid = 1'b1;
            s_ready   = bus.win_ready;
         end
         FEED_HOLD:    s_ready = 1'b1;
      endcase

      // Flush wins the cycle: nothing is accepted and no window is consumed.
      if (flush) begin
         s_ready   = 1'b0;
         win_valid = 1'b0;
      end

      accept  = bus.s_valid & s_ready;
      consume = win_valid & bus.win_ready;
      idx_d   = idx_q + 32'(consume);

      unique case (state_q)
         FEED_FILL: begin
            if (accept) begin
               if (fill_q != FILL_FULL) begin
                  fill_d = fill_q + FILL_W'(1);
               end
               if (fill_d == FILL_FULL) begin
                  state_d = ST_ARM;
                  tmr_d   = TMR_LOAD;
               end
            end
         end
         FEED_SETTLE: begin
            if (tmr_q == '0) begin
               state_d = FEED_PRESENT;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         FEED_PRESENT: begin
            if (consume && accept) begin
               state_d = ST_ARM;
               tmr_d   = TMR_LOAD;
            end else if (consume) begin
               state_d = FEED_HOLD;
            end
         end
         FEED_HOLD: begin
            if (accept) begin
               state_d = ST_ARM;
               tmr_d   = TMR_LOAD;
            end
         end
      endcase

      if (flush) begin
         state_d = FEED_FILL;
         fill_d  = FILL_RST;
         tmr_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FEED_FILL;
         fill_q  <= FILL_RST;
         tmr_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
      end
   end

   fir_delay_line #(
      .N (NTAPS),
      .W (DATA_W)
   ) u_dly (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (flush),
      .shift_en_i (accept),
      .din_i      (ext),
      .taps_o     (bus.taps)
   );

   assign bus.s_ready   = s_ready;
   assign bus.win_valid = win_valid;
   assign bus.win_idx   = idx_q;

endmodule
